jpeg_frame_sequencer: RTL and testbench

//  Frame-level controller between the DMA AXI-Stream ports and the jpeg_axi_stream core.

---
 rtl/jpeg_ctrl_pkg.sv | 21 ++
 rtl/beat_block_counter.sv | 50 +++++
 rtl/jpeg_frame_sequencer.sv | 151 +++++++++++++++
 tb/tb_jpeg_frame_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// jpeg_ctrl_pkg
// Shared definitions for the JPEG frame-level controller:
//   - state_t      : frame sequencer state encoding (3-bit)
//   - DEF_*        : default beat/block geometry used as parameter defaults
// -----------------------------------------------------------------------------
package jpeg_ctrl_pkg;

    localparam int DEF_IN_BEATS  = 64;   // words per 8x8 input block
    localparam int DEF_OUT_BEATS = 64;   // core result words per block
    localparam int DEF_BLK_CNT_W = 16;   // block counter / num_blocks width

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

endpackage

// File: rtl/beat_block_counter.sv
// -----------------------------------------------------------------------------
// beat_block_counter
// Counts handshakes within a block (beat) and completed blocks (blk).
// Ports:
//   aclk, aresetn : clock, synchronous active-low reset
//   clear         : return both counters to zero (wins over step)
//   step          : one accepted word
//   blk           : number of fully transferred blocks
//   last_beat     : current beat is the final word of a block
// -----------------------------------------------------------------------------
module beat_block_counter
    import jpeg_ctrl_pkg::*;
#(
    parameter int BEATS     = DEF_IN_BEATS,
    parameter int BLK_CNT_W = DEF_BLK_CNT_W
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 clear,
    input  logic                 step,
    output logic [BLK_CNT_W-1:0] blk,
    output logic                 last_beat
);

    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0]    BEAT_LAST = BEAT_W'(BEATS - 1);
    localparam logic [BEAT_W-1:0]    BEAT_ONE  = BEAT_W'(1);
    localparam logic [BLK_CNT_W-1:0] BLK_ONE   = BLK_CNT_W'(1);

    logic [BEAT_W-1:0] beat;

    assign last_beat = (beat == BEAT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge aclk) begin
        if (!aresetn || clear) begin
            beat <= '0;
            blk  <= '0;
        end else if (step) begin
            if (last_beat) begin
                beat <= '0;
                blk  <= blk + BLK_ONE;
            end else begin
                beat <= beat + BEAT_ONE;
            end
        end
    end

endmodule

// File: rtl/jpeg_frame_sequencer.sv
// -----------------------------------------------------------------------------
// jpeg_frame_sequencer
// Frame-level controller between DMA AXI-Stream ports and the JPEG core.
// Gates input words into the core in whole blocks, limits blocks in flight,
// counts result blocks and generates the frame-level output tlast.
// Ports:
//   aclk, aresetn        : clock, synchronous active-low reset
//   start, abort         : frame start pulse / return-to-idle pulse
//   num_blocks           : blocks per frame, sampled on accepted start
//   busy, done, err      : status (done is a 1-cycle pulse, err sticky)
//   s00_axis_*           : DMA -> sequencer input stream
//   core_s_*             : sequencer -> core (data pass-through)
//   core_m_*             : core -> sequencer
//   m00_axis_*           : sequencer -> DMA output stream (data pass-through)
// -----------------------------------------------------------------------------
module jpeg_frame_sequencer
    import jpeg_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int IN_BEATS        = DEF_IN_BEATS,
    parameter int OUT_BEATS       = DEF_OUT_BEATS,
    parameter int BLK_CNT_W       = DEF_BLK_CNT_W,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic                  abort,
    input  logic [BLK_CNT_W-1:0]  num_blocks,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic                  s00_axis_tvalid,
    output logic                  s00_axis_tready,
    input  logic [DATA_WIDTH-1:0] s00_axis_tdata,
    input  logic                  s00_axis_tlast,
    output logic                  core_s_tvalid,
    input  logic                  core_s_tready,
    output logic [DATA_WIDTH-1:0] core_s_tdata,
    output logic                  core_s_tlast,
    input  logic                  core_m_tvalid,
    output logic                  core_m_tready,
    input  logic [DATA_WIDTH-1:0] core_m_tdata,
    output logic                  m00_axis_tvalid,
    input  logic                  m00_axis_tready,
    output logic [DATA_WIDTH-1:0] m00_axis_tdata,
    output logic                  m00_axis_tlast
);

    localparam logic [BLK_CNT_W-1:0] MAX_OUT = BLK_CNT_W'(MAX_OUTSTANDING);
    localparam logic [BLK_CNT_W-1:0] BLK_ONE = BLK_CNT_W'(1);

    state_t                state, state_nxt;
    logic [BLK_CNT_W-1:0]  nblk;
    logic [BLK_CNT_W-1:0]  in_blk, out_blk;
    logic                  in_last_beat, out_last_beat;
    logic                  zero_done;
    logic                  start_ok, cnt_clear;
    logic                  in_en, out_en, in_hs, out_hs;
    logic                  last_in_word, last_out_word, tlast_bad;

    // A start with a non-empty frame is only honoured in IDLE and loses to abort.
    assign start_ok  = (state == ST_IDLE) && start && !abort && (num_blocks != '0);
    assign cnt_clear = abort || start_ok;

    // Modular difference is exact because counters never wrap within a frame.
    assign in_en  = (state == ST_RUN) && (in_blk < nblk) && ((in_blk - out_blk) < MAX_OUT);
    assign out_en = (state == ST_RUN) || (state == ST_DRAIN);

    // Valids are gated by enables only, never by the same interface's ready.
    assign s00_axis_tready = core_s_tready & in_en;
    assign core_s_tvalid   = s00_axis_tvalid & in_en;
    assign core_s_tdata    = s00_axis_tdata;
    assign core_s_tlast    = in_last_beat;

    assign core_m_tready   = m00_axis_tready & out_en;
    assign m00_axis_tvalid = core_m_tvalid & out_en;
    assign m00_axis_tdata  = core_m_tdata;

    assign in_hs  = s00_axis_tvalid & core_s_tready & in_en;
    assign out_hs = core_m_tvalid & m00_axis_tready & out_en;

    assign last_in_word   = in_last_beat  && (in_blk  == nblk - BLK_ONE);
    assign last_out_word  = out_last_beat && (out_blk == nblk - BLK_ONE);
    assign m00_axis_tlast = last_out_word;
    // Upstream tlast must coincide exactly with the frame's final word.
    assign tlast_bad      = s00_axis_tlast != last_in_word;

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE) || zero_done;
    // ERR is left only through abort, so the sticky flag is the state itself.
    assign err  = (state == ST_ERR);

    beat_block_counter #(.BEATS(IN_BEATS), .BLK_CNT_W(BLK_CNT_W)) u_in_cnt (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .clear     (cnt_clear),
        .step      (in_hs),
        .blk       (in_blk),
        .last_beat (in_last_beat)
    );

    beat_block_counter #(.BEATS(OUT_BEATS), .BLK_CNT_W(BLK_CNT_W)) u_out_cnt (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .clear     (cnt_clear),
        .step      (out_hs),
        .blk       (out_blk),
        .last_beat (out_last_beat)
    );

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state     <= ST_IDLE;
            nblk      <= '0;
            zero_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            if (start_ok)
                nblk <= num_blocks;
            // Empty frame: report completion one cycle later without leaving IDLE.
            zero_done <= (state == ST_IDLE) && start && !abort && (num_blocks == '0);
        end
    end

    // NOTE: next state gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start_ok) state_nxt = ST_RUN;
                ST_RUN: begin
                    if (in_hs) begin
                        if (tlast_bad)
                            state_nxt = ST_ERR;
                        else if (last_in_word)
                            state_nxt = (out_hs && last_out_word) ? ST_DONE : ST_DRAIN;
                    end
                end
                ST_DRAIN: if (out_hs && last_out_word) state_nxt = ST_DONE;
                ST_DONE:  state_nxt = ST_IDLE;
                ST_ERR:   state_nxt = ST_ERR;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jpeg_frame_sequencer.sv
module tb_jpeg_frame_sequencer;
    import jpeg_ctrl_pkg::*;

    localparam int DW = 32;
    localparam int IB = 64;
    localparam int OB = 64;
    localparam int BW = 16;
    localparam int MO = 2;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [BW-1:0] num_blocks = '0;
    logic          busy, done, err;
    logic          s00_axis_tvalid = 1'b0;
    logic          s00_axis_tready;
    logic [DW-1:0] s00_axis_tdata = '0;
    logic          s00_axis_tlast = 1'b0;
    logic          core_s_tvalid;
    logic          core_s_tready = 1'b0;
    logic [DW-1:0] core_s_tdata;
    logic          core_s_tlast;
    logic          core_m_tvalid;
    logic          core_m_tready;
    logic [DW-1:0] core_m_tdata;
    logic          m00_axis_tvalid;
    logic          m00_axis_tready = 1'b0;
    logic [DW-1:0] m00_axis_tdata;
    logic          m00_axis_tlast;

    always #5 aclk = ~aclk;

    jpeg_frame_sequencer #(
        .DATA_WIDTH(DW), .IN_BEATS(IB), .OUT_BEATS(OB),
        .BLK_CNT_W(BW), .MAX_OUTSTANDING(MO)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .abort(abort),
        .num_blocks(num_blocks), .busy(busy), .done(done), .err(err),
        .s00_axis_tvalid(s00_axis_tvalid), .s00_axis_tready(s00_axis_tready),
        .s00_axis_tdata(s00_axis_tdata), .s00_axis_tlast(s00_axis_tlast),
        .core_s_tvalid(core_s_tvalid), .core_s_tready(core_s_tready),
        .core_s_tdata(core_s_tdata), .core_s_tlast(core_s_tlast),
        .core_m_tvalid(core_m_tvalid), .core_m_tready(core_m_tready),
        .core_m_tdata(core_m_tdata),
        .m00_axis_tvalid(m00_axis_tvalid), .m00_axis_tready(m00_axis_tready),
        .m00_axis_tdata(m00_axis_tdata), .m00_axis_tlast(m00_axis_tlast)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Throttle percentages: chance (0..100) that a given cycle is stalled.
    int in_pct = 0, core_pct = 0, out_pct = 0;

    // Core model: echo FIFO, each word visible one cycle after acceptance.
    logic [DW-1:0] core_mem [0:1023];
    int            wr_ptr = 0, rd_ptr = 0;
    logic          core_out_ok = 1'b0;
    logic          core_push = 1'b0, core_pop = 1'b0;

    assign core_m_tvalid = (wr_ptr != rd_ptr) && core_out_ok;
    assign core_m_tdata  = core_mem[rd_ptr[9:0]];

    always @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr <= 0;
            rd_ptr <= 0;
        end else begin
            if (core_push) begin
                core_mem[wr_ptr[9:0]] <= core_s_tdata;
                wr_ptr <= wr_ptr + 1;
            end
            if (core_pop)
                rd_ptr <= rd_ptr + 1;
        end
    end

    always begin
        @(negedge aclk);
        core_s_tready   = ($urandom_range(99) >= core_pct);
        core_out_ok     = ($urandom_range(99) >= core_pct);
        m00_axis_tready = ($urandom_range(99) >= out_pct);
    end

    // Reference model / scoreboard: word order, frame-level tlast position,
    // block-granular in-flight limit, handshake and pulse counting.
    logic [DW-1:0] exp_q[$];
    int in_cnt = 0, out_cnt = 0, done_cnt = 0, busy_cnt = 0;
    int tlast_cnt = 0, tlast_at = -1, resume_out = -1, frame_words = 0;

    always begin
        @(negedge aclk);
        #3;
        core_push = 1'b0;
        core_pop  = 1'b0;
        if (aresetn) begin
            core_push = core_s_tvalid && core_s_tready;
            core_pop  = core_m_tvalid && core_m_tready;
            if (s00_axis_tvalid && s00_axis_tready) begin
                check("in_limit", ((in_cnt / IB - out_cnt / OB) < MO) && (in_cnt < frame_words), 1);
                check("core_s_tlast", core_s_tlast, (in_cnt % IB) == IB - 1);
                if (in_cnt == 2 * IB) resume_out = out_cnt;
                exp_q.push_back(s00_axis_tdata);
                in_cnt++;
            end
            if (m00_axis_tvalid && m00_axis_tready) begin
                if (exp_q.size() == 0) check("m00_unexpected_word", 1, 0);
                else                   check("m00_tdata", m00_axis_tdata, exp_q.pop_front());
                check("m00_tlast", m00_axis_tlast, out_cnt == frame_words - 1);
                if (m00_axis_tlast) begin
                    tlast_cnt++;
                    tlast_at = out_cnt;
                end
                out_cnt++;
            end
            if (done) done_cnt++;
            if (busy) busy_cnt++;
        end
    end

    task automatic clear_stats();
        in_cnt = 0; out_cnt = 0; done_cnt = 0; busy_cnt = 0;
        tlast_cnt = 0; tlast_at = -1; resume_out = -1;
        exp_q.delete();
    endtask

    task automatic apply_reset();
        @(negedge aclk);
        aresetn = 1'b0; start = 1'b0; abort = 1'b0; s00_axis_tvalid = 1'b0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        clear_stats();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_s00_tready"}, s00_axis_tready, 0);
        check({tag, "_core_s_tvalid"}, core_s_tvalid, 0);
        check({tag, "_core_m_tready"}, core_m_tready, 0);
        check({tag, "_m00_tvalid"}, m00_axis_tvalid, 0);
    endtask

    task automatic pulse_start(input int nb);
        @(negedge aclk);
        start = 1'b1;
        num_blocks = BW'(nb);
        @(negedge aclk);
        start = 1'b0;
        num_blocks = '0;
    endtask

    // Sends words [first, first+count) with random data; tlast only on tlast_idx.
    task automatic send_words(input int first, input int count, input int tlast_idx);
        int i = first;
        int guard = 0;
        logic [DW-1:0] word = $urandom;
        while (i < first + count && guard < 20000) begin
            @(negedge aclk);
            s00_axis_tvalid = ($urandom_range(99) >= in_pct);
            s00_axis_tdata  = word;
            s00_axis_tlast  = (i == tlast_idx);
            #1;
            if (s00_axis_tvalid && s00_axis_tready) begin
                i++;
                word = $urandom;
            end
            guard++;
        end
        @(posedge aclk);
        #1;
        s00_axis_tvalid = 1'b0;
        s00_axis_tlast  = 1'b0;
        if (guard >= 20000) check("send_timeout", i, first + count);
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        while (done_cnt == 0 && c < budget) begin
            @(negedge aclk);
            c++;
        end
        if (done_cnt == 0) check("done_timeout", 0, 1);
        repeat (5) @(negedge aclk);
    endtask

    typedef struct {
        int nb;
        int in_pct;
        int core_pct;
        int out_pct;
        int exp_words;
        int exp_tlast;
        int exp_done;
    } frame_vec_t;

    frame_vec_t vecs[4];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{3,  0,  0,  0, 192, 191, 1};
        vecs[1] = '{5, 50, 50, 50, 320, 319, 1};
        vecs[2] = '{1, 25, 10, 40,  64,  63, 1};
        vecs[3] = '{2,  0, 60, 70, 128, 127, 1};

        // Reset state with every upstream ready/valid asserted.
        repeat (3) @(negedge aclk);
        s00_axis_tvalid = 1'b1;
        #1;
        check_reset_outputs("reset");
        @(negedge aclk);
        s00_axis_tvalid = 1'b0;
        aresetn = 1'b1;
        clear_stats();

        // Full frames, free-flowing and throttled.
        for (int v = 0; v < 4; v++) begin
            in_pct = vecs[v].in_pct; core_pct = vecs[v].core_pct; out_pct = vecs[v].out_pct;
            clear_stats();
            frame_words = vecs[v].nb * OB;
            pulse_start(vecs[v].nb);
            send_words(0, frame_words, frame_words - 1);
            wait_done(20000);
            check("frame_out_words", out_cnt, vecs[v].exp_words);
            check("frame_tlast_count", tlast_cnt, 1);
            check("frame_tlast_pos", tlast_at, vecs[v].exp_tlast);
            check("frame_done_count", done_cnt, vecs[v].exp_done);
            check("frame_err", err, 0);
            check("frame_busy_end", busy, 0);
            check("frame_leftover", exp_q.size(), 0);
        end
        in_pct = 0; core_pct = 0; out_pct = 0;

        // In-flight limit: output held off, input stalls after two blocks.
        clear_stats();
        frame_words = 4 * OB;
        out_pct = 100;
        pulse_start(4);
        fork
            send_words(0, frame_words, frame_words - 1);
            begin
                int c = 0;
                while (in_cnt < 2 * IB && c < 5000) begin
                    @(negedge aclk);
                    c++;
                end
                repeat (20) @(negedge aclk);
                #1;
                check("stall_in_count", in_cnt, 2 * IB);
                check("stall_s00_tready", s00_axis_tready, 0);
                check("stall_core_s_tvalid", core_s_tvalid, 0);
                out_pct = 0;
            end
        join
        wait_done(5000);
        check("stall_resume_after", resume_out, OB);
        check("stall_out_words", out_cnt, 4 * OB);
        check("stall_done_count", done_cnt, 1);

        // Early tlast on word 70: ERR, paths gated, abort recovers.
        clear_stats();
        frame_words = 2 * OB;
        pulse_start(2);
        send_words(0, 71, 70);
        @(negedge aclk);
        s00_axis_tvalid = 1'b1;
        #1;
        check("early_tlast_err", err, 1);
        check("early_tlast_busy", busy, 1);
        check("early_tlast_s00_tready", s00_axis_tready, 0);
        check("early_tlast_core_m_tready", core_m_tready, 0);
        check("early_tlast_words_in", in_cnt, 71);
        @(negedge aclk);
        abort = 1'b1;
        s00_axis_tvalid = 1'b0;
        @(negedge aclk);
        abort = 1'b0;
        #1;
        check("abort_err", err, 0);
        check("abort_busy", busy, 0);
        check("abort_no_done", done_cnt, 0);
        apply_reset();

        // Missing tlast on the final word of the frame.
        frame_words = OB;
        pulse_start(1);
        send_words(0, IB, -1);
        @(negedge aclk);
        #1;
        check("missing_tlast_err", err, 1);
        apply_reset();

        // Empty frame: done pulse next cycle, never busy.
        clear_stats();
        @(negedge aclk);
        start = 1'b1;
        num_blocks = '0;
        @(negedge aclk);
        start = 1'b0;
        #1;
        check("zero_done_pulse", done, 1);
        check("zero_busy", busy, 0);
        @(negedge aclk);
        #1;
        check("zero_done_clears", done, 0);
        repeat (3) @(negedge aclk);
        check("zero_busy_never", busy_cnt, 0);
        check("zero_done_once", done_cnt, 1);

        // Start while running is ignored: frame length stays at 2 blocks.
        clear_stats();
        frame_words = 2 * OB;
        pulse_start(2);
        send_words(0, 10, frame_words - 1);
        pulse_start(7);
        send_words(10, frame_words - 10, frame_words - 1);
        wait_done(5000);
        check("restart_out_words", out_cnt, 2 * OB);
        check("restart_tlast_pos", tlast_at, 2 * OB - 1);
        check("restart_done_count", done_cnt, 1);

        // Reset mid-block, then a normal one-block frame.
        clear_stats();
        frame_words = 2 * OB;
        pulse_start(2);
        send_words(0, 30, -1);
        @(negedge aclk);
        aresetn = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        s00_axis_tvalid = 1'b1;
        #1;
        check_reset_outputs("midreset");
        s00_axis_tvalid = 1'b0;
        clear_stats();
        frame_words = OB;
        pulse_start(1);
        send_words(0, OB, OB - 1);
        wait_done(5000);
        check("post_reset_out_words", out_cnt, OB);
        check("post_reset_done_count", done_cnt, 1);
        check("post_reset_err", err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
